// File: rtl/gabor_pkg.sv
// Shared constants, FSM encoding and Gabor kernel table for the convolution scheduler.
// Latency: n/a (constants and a combinational ROM lookup).
// Backpressure: n/a.
package gabor_pkg;

    localparam int WIDTH       = 128;
    localparam int HEIGHT      = 128;
    localparam int KERNEL_SIZE = 5;
    localparam int NTAPS       = KERNEL_SIZE * KERNEL_SIZE;
    localparam int PIX_W       = 8;
    localparam int COEF_W      = 10;
    localparam int SHIFT       = 9;
    localparam int ADDR_W      = 14;
    localparam int TAP_W       = 5;
    localparam int POS_W       = 7;
    localparam int PROD_W      = PIX_W + COEF_W;
    localparam int ACC_W       = 9;
    localparam int ACC_MAX     = 255;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACC   = 3'd1,
        DRAIN = 3'd2,
        EMIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Q9 coefficients, row-major, m = row, n = column.
    localparam logic [COEF_W-1:0] GABOR_COEF [NTAPS] = '{
        10'd0, 10'd238, 10'd22,  10'd238, 10'd0,
        10'd0, 10'd320, 10'd29,  10'd320, 10'd0,
        10'd0, 10'd353, 10'd512, 10'd353, 10'd0,
        10'd0, 10'd320, 10'd29,  10'd320, 10'd0,
        10'd0, 10'd238, 10'd22,  10'd238, 10'd0
    };

    // Coefficient ROM contents; indices past the last tap read as zero.
    function automatic logic [COEF_W-1:0] gabor_coef(input logic [TAP_W-1:0] idx);
        logic [COEF_W-1:0] val;
        val = '0;
        if (int'(idx) < NTAPS) val = GABOR_COEF[idx];
        return val;
    endfunction

endpackage

// File: rtl/gabor_conv_ctrl_if.sv
// Memory read ports and result stream of the Gabor convolution scheduler.
// Latency: pixel and coefficient data return one cycle after the request.
// Backpressure: result stream is valid/ready; the read ports have none.
interface gabor_conv_ctrl_if;
    import gabor_pkg::*;

    logic                 pix_rd_en;
    logic [ADDR_W-1:0]    pix_addr;
    logic [PIX_W-1:0]     pix_rdata;
    logic [TAP_W-1:0]     coef_idx;
    logic [COEF_W-1:0]    coef;
    logic                 out_valid;
    logic                 out_ready;
    logic [PIX_W-1:0]     out_data;
    logic [POS_W-1:0]     out_row;
    logic [POS_W-1:0]     out_col;
    logic                 out_last;

    modport master (
        output pix_rd_en, pix_addr, coef_idx,
        output out_valid, out_data, out_row, out_col, out_last,
        input  pix_rdata, coef, out_ready
    );

    modport slave (
        input  pix_rd_en, pix_addr, coef_idx,
        input  out_valid, out_data, out_row, out_col, out_last,
        output pix_rdata, coef, out_ready
    );

endinterface

// File: rtl/gabor_tap_mac.sv
// Single shared tap MAC: acc += (pix*coef)>>SHIFT, clamped to 255 after every add.
// Latency: one cycle from enabled operands to updated accumulator.
// Backpressure: none; the caller gates en_i.
module gabor_tap_mac
    import gabor_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [PIX_W-1:0]  pix_i,
    input  logic [COEF_W-1:0] coef_i,
    output logic [PIX_W-1:0]  acc_o
);

    logic [PROD_W-1:0] prod;
    logic [ACC_W:0]    sum;
    logic [ACC_W-1:0]  acc_d;
    logic [ACC_W-1:0]  acc_q;

    // Full-width product, truncating shift, then saturate the running sum.
    always_comb begin
        prod  = PROD_W'(pix_i) * PROD_W'(coef_i);
        sum   = {1'b0, acc_q} + (ACC_W+1)'(prod >> SHIFT);
        acc_d = (sum > (ACC_W+1)'(ACC_MAX)) ? ACC_W'(ACC_MAX) : sum[ACC_W-1:0];
    end

    // Accumulator register; clear has priority over a new contribution.
    always_ff @(posedge clk) begin
        if (reset)      acc_q <= '0;
        else if (clr_i) acc_q <= '0;
        else if (en_i)  acc_q <= acc_d;
    end

    // Clamp keeps the value within 8 bits.
    assign acc_o = acc_q[PIX_W-1:0];

endmodule

// File: rtl/gabor_conv_ctrl.sv
// Frame scheduler for a 5x5 Gabor convolution: raster-scans outputs, one tap per cycle.
// Latency: 27 cycles per output pixel (25 taps + drain + emit); first result in cycle 27.
// Backpressure: EMIT holds the result and issues no reads until out_ready.
module gabor_conv_ctrl
    import gabor_pkg::*;
#(
    parameter int IMG_W = WIDTH,
    parameter int IMG_H = HEIGHT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    gabor_conv_ctrl_if.master bus
);

    state_t             state_q;
    logic [POS_W-1:0]   r_q, c_q, nxt_r, nxt_c;
    logic [TAP_W-1:0]   tap_q;
    logic [2:0]         m_q, n_q, nxt_m, nxt_n;
    logic               busy_q, done_q, rd_en_q, tap_vld_q;
    logic               out_valid_q, out_last_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [TAP_W-1:0]   coef_idx_q;
    logic [POS_W-1:0]   out_row_q, out_col_q;
    logic [PIX_W-1:0]   acc;
    logic               mac_clr;

    // Taps falling past the right or bottom edge are skipped, not zero-padded reads.
    function automatic logic tap_in_img(input logic [POS_W-1:0] r, input logic [POS_W-1:0] c,
                                        input logic [2:0] m, input logic [2:0] n);
        return ((int'(r) + int'(m)) < IMG_H) && ((int'(c) + int'(n)) < IMG_W);
    endfunction

    function automatic logic [ADDR_W-1:0] tap_addr(input logic [POS_W-1:0] r, input logic [POS_W-1:0] c,
                                                   input logic [2:0] m, input logic [2:0] n);
        return ADDR_W'((int'(r) + int'(m)) * IMG_W + int'(c) + int'(n));
    endfunction

    // Next kernel offset (m,n) and next raster position (r,c).
    always_comb begin
        nxt_m = m_q;
        nxt_n = n_q + 3'd1;
        if (n_q == 3'(KERNEL_SIZE - 1)) begin
            nxt_n = '0;
            nxt_m = m_q + 3'd1;
        end
        nxt_r = r_q;
        nxt_c = c_q + POS_W'(1);
        if (c_q == POS_W'(IMG_W - 1)) begin
            nxt_c = '0;
            nxt_r = r_q + POS_W'(1);
        end
    end

    // Accumulator restarts on frame start and on every non-final handoff.
    assign mac_clr = ((state_q == IDLE) && start) ||
                     ((state_q == EMIT) && bus.out_ready && !out_last_q);

    gabor_tap_mac u_mac (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (mac_clr),
        .en_i   (tap_vld_q),
        .pix_i  (bus.pix_rdata),
        .coef_i (bus.coef),
        .acc_o  (acc)
    );

    // Scheduler FSM: counters, read requests and registered result/status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            r_q         <= '0;
            c_q         <= '0;
            tap_q       <= '0;
            m_q         <= '0;
            n_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            tap_vld_q   <= 1'b0;
            addr_q      <= '0;
            coef_idx_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_row_q   <= '0;
            out_col_q   <= '0;
        end else begin
            done_q    <= 1'b0;
            // Read data lands one cycle after the request, so the valid flag trails by one.
            tap_vld_q <= rd_en_q;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= ACC;
                        busy_q     <= 1'b1;
                        r_q        <= '0;
                        c_q        <= '0;
                        tap_q      <= '0;
                        m_q        <= '0;
                        n_q        <= '0;
                        rd_en_q    <= 1'b1;
                        addr_q     <= '0;
                        coef_idx_q <= '0;
                    end
                end
                ACC: begin
                    if (tap_q == TAP_W'(NTAPS - 1)) begin
                        state_q <= DRAIN;
                        rd_en_q <= 1'b0;
                    end else begin
                        tap_q      <= tap_q + TAP_W'(1);
                        m_q        <= nxt_m;
                        n_q        <= nxt_n;
                        coef_idx_q <= tap_q + TAP_W'(1);
                        rd_en_q    <= tap_in_img(r_q, c_q, nxt_m, nxt_n);
                        addr_q     <= tap_addr(r_q, c_q, nxt_m, nxt_n);
                    end
                end
                DRAIN: begin
                    state_q     <= EMIT;
                    out_valid_q <= 1'b1;
                    out_row_q   <= r_q;
                    out_col_q   <= c_q;
                    out_last_q  <= (r_q == POS_W'(IMG_H - 1)) && (c_q == POS_W'(IMG_W - 1));
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        if (out_last_q) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            // Tap (0,0) of any output pixel is always inside the image.
                            state_q    <= ACC;
                            r_q        <= nxt_r;
                            c_q        <= nxt_c;
                            tap_q      <= '0;
                            m_q        <= '0;
                            n_q        <= '0;
                            coef_idx_q <= '0;
                            rd_en_q    <= 1'b1;
                            addr_q     <= tap_addr(nxt_r, nxt_c, 3'd0, 3'd0);
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign bus.pix_rd_en = rd_en_q;
    assign bus.pix_addr  = addr_q;
    assign bus.coef_idx  = coef_idx_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = acc;
    assign bus.out_row   = out_row_q;
    assign bus.out_col   = out_col_q;
    assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_gabor_conv_ctrl.sv
// Bench for gabor_conv_ctrl on a reduced 8x6 image with pixel memory and coefficient ROM models.
// Expected results come from an independent convolution model queued at frame start.
// Ready is driven always-high, random or held low depending on the scenario.
module tb_gabor_conv_ctrl;
    import gabor_pkg::*;

    localparam int TW   = 8;
    localparam int TH   = 6;
    localparam int NPIX = TW * TH;
    localparam int BUD  = 4 * 27 * NPIX + 200;

    typedef struct {
        int data;
        int row;
        int col;
        int last;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic busy;
    logic done;

    gabor_conv_ctrl_if bus ();

    gabor_conv_ctrl #(.IMG_W(TW), .IMG_H(TH)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int KC [NTAPS] = '{0, 238, 22, 238, 0,
                       0, 320, 29, 320, 0,
                       0, 353, 512, 353, 0,
                       0, 320, 29, 320, 0,
                       0, 238, 22, 238, 0};

    logic [7:0] img [NPIX];
    exp_t       expq [$];
    int         got [NPIX];
    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         t_start = 0;
    int         first_vld = -1;
    int         done_lat = -1;
    int         n_done = 0;
    int         nd_base = 0;
    int         n_xfer = 0;
    int         rdy_mode = 0;
    int         restart_at = -1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model(input int r, input int c);
        int acc;
        acc = 0;
        for (int m = 0; m < 5; m++) begin
            for (int n = 0; n < 5; n++) begin
                if (r + m < TH && c + n < TW) begin
                    acc = acc + ((int'(img[(r + m) * TW + c + n]) * KC[m * 5 + n]) >>> 9);
                    if (acc > 255) acc = 255;
                end
            end
        end
        return acc;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Pixel memory and coefficient ROM, one cycle read latency.
    always @(posedge clk) begin
        if (bus.pix_rd_en)
            bus.pix_rdata <= (int'(bus.pix_addr) < NPIX) ? img[bus.pix_addr] : 8'hEE;
        bus.coef <= gabor_coef(bus.coef_idx);
    end

    // Downstream ready driver.
    always @(posedge clk) begin
        int md;
        md = rdy_mode;
        #1;
        if (md == 0)      bus.out_ready = 1'b1;
        else if (md == 1) bus.out_ready = 1'($urandom_range(0, 1));
        else              bus.out_ready = 1'b0;
    end

    // Scoreboard and timing monitor, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (bus.out_valid && first_vld < 0) first_vld = cyc - t_start;
        if (done) begin
            done_lat = cyc - t_start;
            n_done++;
        end
        if (bus.out_valid && bus.out_ready) begin
            n_xfer++;
            if (expq.size() == 0) begin
                chk("extra_out", 1, 0);
            end else begin
                e = expq.pop_front();
                chk("out_data", int'(bus.out_data), e.data);
                chk("out_row", int'(bus.out_row), e.row);
                chk("out_col", int'(bus.out_col), e.col);
                chk("out_last", int'(bus.out_last), e.last);
                got[e.row * TW + e.col] = int'(bus.out_data);
            end
        end
    end

    task automatic start_frame();
        exp_t e;
        for (int r = 0; r < TH; r++) begin
            for (int c = 0; c < TW; c++) begin
                e.data = model(r, c);
                e.row  = r;
                e.col  = c;
                e.last = (r == TH - 1 && c == TW - 1) ? 1 : 0;
                expq.push_back(e);
            end
        end
        first_vld = -1;
        done_lat  = -1;
        nd_base   = n_done;
        @(posedge clk); #1;
        start   = 1'b1;
        t_start = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_cycle1", int'(busy), 1);
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (n_done == nd_base && k < budget) begin
            @(posedge clk); #1;
            start = (k == restart_at);
            k++;
        end
        start = 1'b0;
        if (n_done == nd_base) chk("done_timeout", 0, 1);
    endtask

    task automatic end_checks(input bit check_lat);
        chk("first_vld_cycle", first_vld, 27);
        if (check_lat) chk("done_cycle", done_lat, 27 * NPIX + 1);
        chk("exp_left", expq.size(), 0);
        @(posedge clk); #1;
        chk("done_one_pulse", int'(done), 0);
        chk("busy_idle", int'(busy), 0);
    endtask

    initial begin
        int k;
        int sd, sr, sc, x0;
        reset    = 1'b1;
        start    = 1'b0;
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_valid", int'(bus.out_valid), 0);
        chk("rst_rd_en", int'(bus.pix_rd_en), 0);
        chk("rst_addr", int'(bus.pix_addr), 0);
        chk("rst_coef_idx", int'(bus.coef_idx), 0);
        chk("rst_data", int'(bus.out_data), 0);
        chk("rst_row", int'(bus.out_row), 0);
        chk("rst_col", int'(bus.out_col), 0);
        chk("rst_last", int'(bus.out_last), 0);
        reset = 1'b0;

        // All-zero image, ready always high.
        for (int i = 0; i < NPIX; i++) img[i] = 8'd0;
        start_frame();
        wait_done(BUD);
        end_checks(1'b1);

        // Single impulse at (2,2).
        img[2 * TW + 2] = 8'd100;
        start_frame();
        wait_done(BUD);
        end_checks(1'b1);
        chk("imp_0_0", got[0], 100);
        chk("imp_1_1", got[1 * TW + 1], 62);
        chk("imp_2_1", got[2 * TW + 1], 46);
        chk("imp_2_2", got[2 * TW + 2], 0);

        // Saturated image, random ready, start re-pulsed mid-frame.
        for (int i = 0; i < NPIX; i++) img[i] = 8'd255;
        rdy_mode   = 1;
        restart_at = 300;
        start_frame();
        wait_done(BUD);
        end_checks(1'b0);
        restart_at = -1;
        chk("sat_0_0", got[0], 255);
        chk("sat_corner", got[(TH - 1) * TW + TW - 1], 0);
        chk("sat_lastrow", got[(TH - 1) * TW + TW - 2], 118);
        chk("sat_lastcol", got[(TH - 2) * TW + TW - 1], 0);

        // Stall at the first result.
        for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom_range(0, 255));
        rdy_mode = 2;
        start_frame();
        k = 0;
        while (!bus.out_valid && k < 60) begin
            @(posedge clk); #1;
            k++;
        end
        chk("stall_vld_seen", int'(bus.out_valid), 1);
        sd = int'(bus.out_data);
        sr = int'(bus.out_row);
        sc = int'(bus.out_col);
        for (int i = 0; i < 10; i++) begin
            chk("stall_valid", int'(bus.out_valid), 1);
            chk("stall_data", int'(bus.out_data), sd);
            chk("stall_row", int'(bus.out_row), sr);
            chk("stall_col", int'(bus.out_col), sc);
            chk("stall_rd_en", int'(bus.pix_rd_en), 0);
            @(posedge clk); #1;
        end
        rdy_mode = 0;
        @(posedge clk); #1;
        chk("stall_hold_valid", int'(bus.out_valid), 1);
        chk("stall_hold_data", int'(bus.out_data), sd);
        @(posedge clk); #1;
        chk("post_xfer_valid", int'(bus.out_valid), 0);
        chk("post_xfer_rd_en", int'(bus.pix_rd_en), 1);
        chk("post_xfer_coef_idx", int'(bus.coef_idx), 0);
        wait_done(BUD);
        end_checks(1'b0);

        // Reset in the middle of a frame.
        for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom_range(0, 255));
        start_frame();
        x0 = n_xfer;
        k  = 0;
        while (n_xfer < x0 + 20 && k < 27 * 25) begin
            @(posedge clk); #1;
            k++;
        end
        chk("pre_reset_xfers", (n_xfer >= x0 + 20) ? 1 : 0, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_valid", int'(bus.out_valid), 0);
        chk("mid_rst_rd_en", int'(bus.pix_rd_en), 0);
        chk("mid_rst_data", int'(bus.out_data), 0);
        expq.delete();
        x0 = n_xfer;
        repeat (40) @(posedge clk);
        #1;
        chk("no_out_after_rst", n_xfer - x0, 0);

        // Start coincident with reset is dropped.
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        chk("rst_start_busy", int'(busy), 0);
        @(posedge clk); #1;
        chk("rst_start_busy2", int'(busy), 0);
        chk("rst_start_rd_en", int'(bus.pix_rd_en), 0);

        // Fresh frame after reset restarts at (0,0).
        rdy_mode = 1;
        start_frame();
        wait_done(BUD);
        end_checks(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gabor_conv_ctrl.md
Name: gabor_conv_ctrl

Overview:
- Sequencing controller for the 5x5 Gabor convolution over a 128x128 8-bit image.
- On a start pulse it raster-scans every output pixel, drives read addresses to an external pixel memory and an external coefficient ROM, and sequences one shared tap MAC one tap per cycle.
- It saturates each result and hands it to a downstream writer over a valid/ready interface.
- It replaces the all-at-once combinational convolution with a deterministic, stallable, frame-level scheduler.

Parameters:
- WIDTH, 128, image columns.
- HEIGHT, 128, image rows.
- KERNEL_SIZE, 5, kernel side length; 25 taps.
- PIX_W, 8, pixel width.
- COEF_W, 10, unsigned coefficient width, Q9.
- SHIFT, 9, right shift applied to each product.
- ADDR_W, 14, clog2(WIDTH*HEIGHT).

Ports:
- clk  in  1  clock
- reset  in  1  reset
- start  in  1  one-cycle request to process a frame; ignored while busy
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the final output transfer
- pix_rd_en  out  1  pixel memory read enable
- pix_addr  out  ADDR_W  row-major address, (r+m)*WIDTH+(c+n)
- pix_rdata  in  PIX_W  pixel data, valid 1 cycle after pix_rd_en
- coef_idx  out  5  tap index m*KERNEL_SIZE+n
- coef  in  COEF_W  coefficient, valid 1 cycle after coef_idx
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts the result
- out_data  out  PIX_W  saturated result
- out_row  out  7  output row r
- out_col  out  7  output column c
- out_last  out  1  high with out_valid when (r,c) = (HEIGHT-1, WIDTH-1)

Behaviour:
- Clocking and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; r=c=0; tap=0; acc=0.
- Reset mid-frame: the next edge forces IDLE and clears all outputs. Any outstanding read is discarded and no result is emitted.
- FSM: IDLE -> ACC -> DRAIN -> EMIT -> (ACC | DONE) -> IDLE.
- IDLE:
  - Waits for start.
  - On start: r=c=0, tap=0, acc=0, busy=1; go to ACC.
- ACC (exactly 25 cycles, tap t=0..24, m=t/5, n=t%5):
  - coef_idx=t every cycle.
  - If r+m<HEIGHT and c+n<WIDTH: pix_rd_en=1 and pix_addr is driven.
  - Otherwise pix_rd_en=0 and the tap contributes 0.
  - Valid-flag pipeline: data for tap t accumulates in cycle t+1.
- DRAIN (1 cycle): accumulates tap 24; no read issued.
- Accumulate rule:
  - acc += (pix_rdata*coef)>>SHIFT, using an 18-bit product, truncating shift.
  - acc is clamped to 255 after every addition; acc is 9 bits minimum.
- EMIT:
  - out_valid=1; out_data=acc, already saturated; out_row=r; out_col=c.
  - out_data, out_row, out_col and out_last hold stable while out_ready=0. No reads are issued while stalled.
  - On out_valid&&out_ready: if last, go to DONE. Otherwise c++ (wrapping to 0 with r++ at c=WIDTH-1), acc=0, tap=0, go to ACC.
  - out_valid deasserts in the cycle after the transfer.
- DONE: done=1 for one cycle, busy=0; go to IDLE.
- Latency: start sampled at cycle 0; ACC in cycles 1..25; DRAIN in cycle 26; first out_valid in cycle 27.
- Throughput: with out_ready tied high, 27 cycles per pixel. done pulses at cycle 27*16384+1 = 442369.
- Boundaries: no zero-pad reads past the right or bottom edge. Corner output (127,127) uses only tap (0,0).
- start during busy: no effect. start coincident with reset: reset wins.

Decomposition:
- gabor_pkg holds:
  - WIDTH, HEIGHT, KERNEL_SIZE, PIX_W, COEF_W, SHIFT, ADDR_W.
  - State encoding: IDLE, ACC, DRAIN, EMIT, DONE.
  - The 25 kernel constants, rows 0..4:
    - row 0: 0,238,22,238,0
    - row 1: 0,320,29,320,0
    - row 2: 0,353,512,353,0
    - row 3: 0,320,29,320,0
    - row 4: 0,238,22,238,0
  - The coefficient ROM uses these constants.
- One sub-module, gabor_tap_mac: multiply, shift, accumulate with per-step clamp to 255, with clear and enable inputs.
- The controller owns the FSM, counters and address generation.

Test Plan:
- All pixels 0, out_ready=1 -> 16384 transfers, all out_data=0; out_last only at (127,127); done at cycle 442369 after start.
- Only pixel addr 258 = 100, all others 0 ->
  - out(0,0)=100 (coef 512)
  - out(1,1)=62 (32000>>9)
  - out(2,1)=46 (coef 238)
  - out(2,2)=0 (coef 0)
- All pixels 255 -> out(0,0)=255 (saturated); out(127,126)=118; out(127,127)=0; out(126,127)=0.
- out_ready held 0 for 10 cycles at the first out_valid -> out_data, out_row and out_col stable, pix_rd_en=0 throughout. Transfer occurs on the first ready cycle; the next ACC starts in the following cycle.
- reset pulsed for 1 cycle after 100 transfers -> busy=0 and out_valid=0 from the next cycle. A new start restarts at (0,0) with first out_valid 27 cycles after start.
- start re-pulsed while busy -> ignored; output count and ordering unchanged.
